pe_array_tile_acc: RTL

- Parametrised successor to the fixed 16-PE fused array.
- Computes a signed multi-precision dot product over N_ELEM element pairs per beat, accumulates across a programmable tile of beats (bias seeded on the first beat), and emits one saturated partial sum per tile.
- Sits between the act/weight buffers and the output writeback, with valid/ready handshakes on both sides.

---
 rtl/pe_array_tile_acc_pkg.sv | 29 ++
 rtl/pe_array_tile_acc_bitfusion_mult8.sv | 50 +++++
 rtl/pe_array_tile_acc.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pe_array_tile_acc_pkg.sv
// Shared types and helpers for the tiled PE dot-product accumulator.
// The sum-width macro gives the adder-tree output width for n element products.
`define PE_SUM_W(n) (16 + $clog2(n))

package pe_array_tile_acc_pkg;

  localparam int DEF_N_ELEM = 16;
  localparam int DEF_PSUM_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_BIAS_W = 32;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    PREC_2B  = 2'b00,
    PREC_4B  = 2'b01,
    PREC_8B  = 2'b10,
    PREC_RSV = 2'b11
  } prec_e;

  // Reserved code behaves as full 8b precision.
  function automatic int prec_bits(input logic [1:0] code);
    case (prec_e'(code))
      PREC_2B: return 2;
      PREC_4B: return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/pe_array_tile_acc_bitfusion_mult8.sv
// Signed 8b x 8b multiplier built from sixteen 2b x 2b slices; the precision
// code selects how many slices are live and which slice carries the sign.
module bitfusion_mult8
  import pe_array_tile_acc_pkg::*;
(
  input  logic [7:0]        act_i,
  input  logic [7:0]        wgt_i,
  input  logic [1:0]        act_prec_i,
  input  logic [1:0]        wgt_prec_i,
  output logic signed [15:0] prod_o
);

  int a_n;
  int w_n;
  logic signed [2:0] a_sl [4];
  logic signed [2:0] w_sl [4];

  always_comb begin
    a_n = prec_bits(act_prec_i) / 2;
    w_n = prec_bits(wgt_prec_i) / 2;
    for (int i = 0; i < 4; i++) begin
      a_sl[i] = '0;
      w_sl[i] = '0;
      // Slices above the active width are dropped; the topmost live slice is signed.
      if (i < a_n) begin
        a_sl[i] = (i == a_n - 1) ? {act_i[2*i+1], act_i[2*i +: 2]} : {1'b0, act_i[2*i +: 2]};
      end
      if (i < w_n) begin
        w_sl[i] = (i == w_n - 1) ? {wgt_i[2*i+1], wgt_i[2*i +: 2]} : {1'b0, wgt_i[2*i +: 2]};
      end
    end
  end

  logic signed [5:0]  pp;
  logic signed [15:0] acc;

  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp  = a_sl[i] * w_sl[j];
        acc = acc + (16'(pp) << (2 * (i + j)));
      end
    end
  end

  assign prod_o = acc;

endmodule

// File: rtl/pe_array_tile_acc.sv
// Tiled signed dot-product engine: N_ELEM products per beat, adder tree,
// bias-seeded tile accumulator and a saturated, backpressured result register.
module pe_array_tile_acc
  import pe_array_tile_acc_pkg::*;
#(
  parameter int N_ELEM = DEF_N_ELEM,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int BIAS_W = DEF_BIAS_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic [8*N_ELEM-1:0] i_Act,
  input  logic [8*N_ELEM-1:0] i_Weight,
  input  logic [3:0]          i_Precision,
  input  logic [BIAS_W-1:0]   i_Bias,
  input  logic [LEN_W-1:0]    i_Len,
  input  logic                i_Flush,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic [PSUM_W-1:0]   o_Psum,
  output logic                o_Sat
);

  localparam int SUM_W = `PE_SUM_W(N_ELEM);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

  // Handshake: a beat moves in when i_Valid && o_Ready; a result leaves when
  // o_Valid && i_Ready. The whole pipe freezes only while a result is stuck.
  logic en;
  logic accept;
  logic o_valid_q;

  assign en      = !(o_valid_q && !i_Ready);
  assign o_Ready = en && !i_Flush;
  assign accept  = i_Valid && o_Ready;

  // Tile control
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_eff;
  logic [3:0]       prec_q, prec_cur;
  logic             beat_first, beat_last;

  always_comb begin
    beat_first = (cnt_q == '0);
    if (beat_first) begin
      len_eff  = (i_Len == '0) ? LEN_W'(1) : i_Len;
      prec_cur = i_Precision;
    end else begin
      len_eff  = len_q;
      prec_cur = prec_q;
    end
    beat_last = (cnt_q == len_eff - LEN_W'(1));
    cnt_d     = beat_last ? '0 : cnt_q + LEN_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      len_q  <= '0;
      prec_q <= '0;
    end else if (i_Flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_d;
      if (beat_first) begin
        len_q  <= len_eff;
        prec_q <= i_Precision;
      end
    end
  end

  logic [N_ELEM-1:0][15:0] prod_w;

  for (genvar g = 0; g < N_ELEM; g++) begin : g_mult
    bitfusion_mult8 u_mult (
      .act_i      (i_Act[8*g +: 8]),
      .wgt_i      (i_Weight[8*g +: 8]),
      .act_prec_i (prec_cur[3:2]),
      .wgt_prec_i (prec_cur[1:0]),
      .prod_o     (prod_w[g])
    );
  end

  // S1: products. Bias travels with the beat so back-to-back tiles cannot clobber it.
  logic                    s1_vld_q, s1_first_q, s1_last_q;
  logic [BIAS_W-1:0]       s1_bias_q;
  logic [N_ELEM-1:0][15:0] s1_prod_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      s1_prod_q  <= '0;
    end else if (i_Flush) begin
      s1_vld_q <= 1'b0;
    end else if (en) begin
      s1_vld_q   <= accept;
      s1_first_q <= beat_first;
      s1_last_q  <= beat_last;
      s1_bias_q  <= i_Bias;
      s1_prod_q  <= prod_w;
    end
  end

  logic signed [SUM_W-1:0] tree_sum;

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      tree_sum = tree_sum + SUM_W'($signed(s1_prod_q[i]));
    end
  end

  // S2: adder-tree sum
  logic                    s2_vld_q, s2_first_q, s2_last_q;
  logic [BIAS_W-1:0]       s2_bias_q;
  logic signed [SUM_W-1:0] s2_sum_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_bias_q  <= '0;
      s2_sum_q   <= '0;
    end else if (i_Flush) begin
      s2_vld_q <= 1'b0;
    end else if (en) begin
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_bias_q  <= s1_bias_q;
      s2_sum_q   <= tree_sum;
    end
  end

  // S3: accumulator plus saturation of the next value into the output register
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_hi, sat_lo;
  logic [PSUM_W-1:0]       psum_d;

  always_comb begin
    acc_d  = (s2_first_q ? ACC_W'($signed(s2_bias_q)) : acc_q) + ACC_W'(s2_sum_q);
    sat_hi = (acc_d > SAT_MAX);
    sat_lo = (acc_d < SAT_MIN);
    psum_d = acc_d[PSUM_W-1:0];
    if (sat_hi) psum_d = SAT_MAX[PSUM_W-1:0];
    if (sat_lo) psum_d = SAT_MIN[PSUM_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
    end else if (i_Flush) begin
      acc_q <= '0;
    end else if (en && s2_vld_q) begin
      acc_q <= acc_d;
    end
  end

  logic [PSUM_W-1:0] o_psum_q;
  logic              o_sat_q;

  // With en high any held result is being drained, so a new last beat simply reloads.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_valid_q <= 1'b0;
      o_psum_q  <= '0;
      o_sat_q   <= 1'b0;
    end else if (i_Flush) begin
      o_valid_q <= 1'b0;
    end else if (en) begin
      o_valid_q <= s2_vld_q && s2_last_q;
      if (s2_vld_q && s2_last_q) begin
        o_psum_q <= psum_d;
        o_sat_q  <= sat_hi || sat_lo;
      end
    end
  end

  assign o_Valid = o_valid_q;
  assign o_Psum  = o_psum_q;
  assign o_Sat   = o_sat_q;

endmodule
